// File: rtl/pong_pkg.sv
// Shared definitions for the pong game controller: FSM state encodings,
// UART command bytes and the decoded-command record.
package pong_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_POINT = 3'd4;
    localparam logic [2:0] ST_OVER  = 3'd5;

    localparam logic [7:0] CMD_UP      = 8'h77;
    localparam logic [7:0] CMD_DOWN    = 8'h73;
    localparam logic [7:0] CMD_STOP    = 8'h00;
    localparam logic [7:0] CMD_START   = 8'h20;
    localparam logic [7:0] CMD_RESTART = 8'h72;

    typedef struct packed {
        logic up;
        logic down;
        logic stop;
        logic start;
        logic restart;
    } cmd_t;

    // Unknown bytes decode to all-zero so they cannot disturb state or latches.
    function automatic cmd_t decode_cmd(input logic dv, input logic [7:0] b);
        cmd_t c;
        c = '0;
        if (dv) begin
            case (b)
                CMD_UP:      c.up      = 1'b1;
                CMD_DOWN:    c.down    = 1'b1;
                CMD_STOP:    c.stop    = 1'b1;
                CMD_START:   c.start   = 1'b1;
                CMD_RESTART: c.restart = 1'b1;
                default:     c = '0;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/pong_tick_gen.sv
// Free-running frame-tick divider: counts 0..TICK_DIV-1 and flags the wrap cycle.
module pong_tick_gen #(
    parameter int TICK_DIV = 833333
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: decodes UART commands, runs serve/play/pause/score
// flow and gates frame ticks into physics and paddle strobes.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int TICK_DIV    = 833333,
    parameter int SERVE_DELAY = 60,
    parameter int WIN_SCORE   = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_dv,
    input  logic [7:0] rx_byte,
    input  logic       miss_player,
    input  logic       miss_ai,
    output logic       phys_tick,
    output logic       serve_load,
    output logic       serve_dir,
    output logic       paddle_up,
    output logic       paddle_down,
    output logic [3:0] player_score,
    output logic [3:0] ai_score,
    output logic [2:0] state,
    output logic       game_over,
    output logic       winner
);

    localparam int DLY_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == 4'd15) ? s : s + 4'd1;
    endfunction

    logic tick;
    cmd_t cmd;

    logic [2:0]       state_q, state_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             up_q, up_d;
    logic             dn_q, dn_d;
    logic [3:0]       ps_q, ps_d;
    logic [3:0]       as_q, as_d;
    logic             dir_q, dir_d;
    logic             win_q, win_d;
    logic             go_q, go_d;
    logic             phys_q, phys_d;
    logic             sl_q, sl_d;
    logic             pu_q, pu_d;
    logic             pd_q, pd_d;
    logic             serve_done;

    pong_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign cmd        = decode_cmd(rx_dv, rx_byte);
    assign serve_done = (int'(dly_q) + 1 >= SERVE_DELAY);

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        up_d    = up_q;
        dn_d    = dn_q;
        ps_d    = ps_q;
        as_d    = as_q;
        dir_d   = dir_q;
        win_d   = win_q;
        phys_d  = 1'b0;
        sl_d    = 1'b0;
        pu_d    = 1'b0;
        pd_d    = 1'b0;

        // Restart overrides everything else seen in the same cycle, including ticks and misses.
        if (cmd.restart) begin
            state_d = ST_IDLE;
            dly_d   = '0;
            up_d    = 1'b0;
            dn_d    = 1'b0;
            ps_d    = '0;
            as_d    = '0;
        end else begin
            if (cmd.up) begin
                up_d = 1'b1;
                dn_d = 1'b0;
            end else if (cmd.down) begin
                up_d = 1'b0;
                dn_d = 1'b1;
            end else if (cmd.stop) begin
                up_d = 1'b0;
                dn_d = 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (cmd.start) begin
                        state_d = ST_SERVE;
                        dly_d   = '0;
                    end
                end
                ST_SERVE: begin
                    if (tick) begin
                        if (serve_done) begin
                            sl_d    = 1'b1;
                            state_d = ST_PLAY;
                            dly_d   = '0;
                        end else begin
                            dly_d = dly_q + DLY_W'(1);
                        end
                    end
                end
                ST_PLAY: begin
                    phys_d = tick;
                    pu_d   = up_q & tick;
                    pd_d   = dn_q & tick;
                    // A miss ends the rally even if a pause arrives in the same cycle.
                    if (miss_ai || miss_player) begin
                        state_d = ST_POINT;
                        if (miss_ai && !miss_player) begin
                            ps_d  = sat_inc(ps_q);
                            dir_d = 1'b1;
                        end else if (miss_player && !miss_ai) begin
                            as_d  = sat_inc(as_q);
                            dir_d = 1'b0;
                        end
                    end else if (cmd.start) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (cmd.start) begin
                        state_d = ST_PLAY;
                    end
                end
                ST_POINT: begin
                    if ((ps_q >= WIN) || (as_q >= WIN)) begin
                        state_d = ST_OVER;
                        win_d   = (as_q >= WIN);
                    end else begin
                        state_d = ST_SERVE;
                        dly_d   = '0;
                    end
                end
                ST_OVER: begin
                    if (cmd.start) begin
                        state_d = ST_IDLE;
                        ps_d    = '0;
                        as_d    = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        go_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dly_q   <= '0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            ps_q    <= '0;
            as_q    <= '0;
            dir_q   <= 1'b0;
            win_q   <= 1'b0;
            go_q    <= 1'b0;
            phys_q  <= 1'b0;
            sl_q    <= 1'b0;
            pu_q    <= 1'b0;
            pd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            ps_q    <= ps_d;
            as_q    <= as_d;
            dir_q   <= dir_d;
            win_q   <= win_d;
            go_q    <= go_d;
            phys_q  <= phys_d;
            sl_q    <= sl_d;
            pu_q    <= pu_d;
            pd_q    <= pd_d;
        end
    end

    assign state        = state_q;
    assign phys_tick    = phys_q;
    assign serve_load   = sl_q;
    assign serve_dir    = dir_q;
    assign paddle_up    = pu_q;
    assign paddle_down  = pd_q;
    assign player_score = ps_q;
    assign ai_score     = as_q;
    assign game_over    = go_q;
    assign winner       = win_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with TICK_DIV=4, SERVE_DELAY=2, WIN_SCORE=3.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       miss_player;
    logic       miss_ai;
    logic       phys_tick;
    logic       serve_load;
    logic       serve_dir;
    logic       paddle_up;
    logic       paddle_down;
    logic [3:0] player_score;
    logic [3:0] ai_score;
    logic [2:0] state;
    logic       game_over;
    logic       winner;

    pong_game_ctrl #(
        .TICK_DIV   (4),
        .SERVE_DELAY(2),
        .WIN_SCORE  (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_dv       (rx_dv),
        .rx_byte     (rx_byte),
        .miss_player (miss_player),
        .miss_ai     (miss_ai),
        .phys_tick   (phys_tick),
        .serve_load  (serve_load),
        .serve_dir   (serve_dir),
        .paddle_up   (paddle_up),
        .paddle_down (paddle_down),
        .player_score(player_score),
        .ai_score    (ai_score),
        .state       (state),
        .game_over   (game_over),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       ph;
        logic       sl;
        logic       up;
        logic       dn;
        logic [3:0] ps;
        logic [3:0] as;
        logic       dir;
        logic       go;
        logic       win;
    } out_t;

    typedef struct {
        int         cyc;
        logic       dv;
        logic [7:0] data;
        logic       mp;
        logic       ma;
        out_t       exp;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ri      = 0;
    int   last_cyc;
    out_t exp_o;
    out_t acc;
    out_t seen_o;
    logic seen;

    function automatic out_t get_out();
        out_t o;
        o.st  = state;
        o.ph  = phys_tick;
        o.sl  = serve_load;
        o.up  = paddle_up;
        o.dn  = paddle_down;
        o.ps  = player_score;
        o.as  = ai_score;
        o.dir = serve_dir;
        o.go  = game_over;
        o.win = winner;
        return o;
    endfunction

    function automatic string fmt(out_t o);
        return $sformatf("st=%0d ph=%0b sl=%0b up=%0b dn=%0b ps=%0d ai=%0d dir=%0b go=%0b win=%0b",
                         o.st, o.ph, o.sl, o.up, o.dn, o.ps, o.as, o.dir, o.go, o.win);
    endfunction

    task automatic check(input string name, input out_t act, input out_t req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(req));
        end
    endtask

    task automatic drive(input logic dv, input logic [7:0] d, input logic mp, input logic ma);
        rx_dv       = dv;
        rx_byte     = d;
        miss_player = mp;
        miss_ai     = ma;
    endtask

    task automatic add(input int cyc, input logic dv, input logic [7:0] d, input logic mp,
                       input logic ma, input logic [2:0] st, input logic ph, input logic sl,
                       input logic up, input logic dn, input logic [3:0] ps, input logic [3:0] as,
                       input logic dir, input logic go, input logic win);
        vec_t v;
        v.cyc  = cyc;
        v.dv   = dv;
        v.data = d;
        v.mp   = mp;
        v.ma   = ma;
        v.exp  = '{st: st, ph: ph, sl: sl, up: up, dn: dn, ps: ps, as: as, dir: dir, go: go, win: win};
        vecs.push_back(v);
    endtask

    initial begin
        // Edge k counts clock edges after reset release; the frame tick falls on every k%4==0.
        //   cyc  dv  byte   mp ma   st ph sl up dn ps as dir go win
        add(  1, 1, 8'h20, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(  8, 0, 8'h00, 0, 0,   2, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add( 12, 0, 8'h00, 0, 0,   2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add( 13, 1, 8'h77, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add( 16, 0, 8'h00, 0, 0,   2, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        add( 17, 1, 8'h00, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add( 20, 0, 8'h00, 0, 0,   2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add( 21, 1, 8'h77, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add( 22, 1, 8'h41, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add( 23, 1, 8'h42, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add( 24, 0, 8'h00, 0, 0,   2, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        add( 25, 1, 8'h00, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add( 28, 0, 8'h00, 0, 0,   2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add( 29, 1, 8'h73, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add( 32, 0, 8'h00, 0, 0,   2, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        add( 33, 1, 8'h00, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add( 34, 0, 8'h00, 0, 1,   4, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        add( 35, 0, 8'h00, 0, 0,   1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        add( 40, 0, 8'h00, 0, 0,   2, 0, 1, 0, 0, 1, 0, 1, 0, 0);
        add( 44, 0, 8'h00, 0, 0,   2, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        add( 45, 0, 8'h00, 0, 1,   4, 0, 0, 0, 0, 2, 0, 1, 0, 0);
        add( 46, 0, 8'h00, 0, 0,   1, 0, 0, 0, 0, 2, 0, 1, 0, 0);
        add( 52, 0, 8'h00, 0, 0,   2, 0, 1, 0, 0, 2, 0, 1, 0, 0);
        add( 53, 0, 8'h00, 0, 1,   4, 0, 0, 0, 0, 3, 0, 1, 0, 0);
        add( 54, 0, 8'h00, 0, 0,   5, 0, 0, 0, 0, 3, 0, 1, 1, 0);
        add( 55, 0, 8'h00, 1, 0,   5, 0, 0, 0, 0, 3, 0, 1, 1, 0);
        add( 57, 1, 8'h20, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add( 58, 1, 8'h20, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add( 64, 0, 8'h00, 0, 0,   2, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        add( 65, 0, 8'h00, 1, 1,   4, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add( 66, 0, 8'h00, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add( 72, 0, 8'h00, 0, 0,   2, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        add( 73, 1, 8'h20, 0, 0,   3, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add( 77, 0, 8'h00, 1, 0,   3, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add( 93, 1, 8'h20, 0, 0,   2, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add( 96, 0, 8'h00, 0, 0,   2, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        add( 97, 0, 8'h00, 1, 0,   4, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add( 98, 0, 8'h00, 0, 0,   1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(104, 0, 8'h00, 0, 0,   2, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        add(105, 0, 8'h00, 1, 0,   4, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        add(106, 0, 8'h00, 0, 0,   1, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        add(112, 0, 8'h00, 0, 0,   2, 0, 1, 0, 0, 0, 2, 0, 0, 0);
        add(113, 1, 8'h77, 0, 0,   2, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        add(116, 1, 8'h72, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(117, 1, 8'h20, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(124, 0, 8'h00, 0, 0,   2, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(128, 0, 8'h00, 0, 0,   2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(129, 1, 8'h72, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(130, 1, 8'h20, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        last_cyc = 131;

        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", get_out(), '0);
        rst = 1'b0;

        exp_o = '0;
        for (int k = 1; k <= last_cyc; k++) begin
            if (ri < vecs.size() && vecs[ri].cyc == k) begin
                drive(vecs[ri].dv, vecs[ri].data, vecs[ri].mp, vecs[ri].ma);
                exp_o = vecs[ri].exp;
                ri++;
            end else begin
                drive(1'b0, 8'h00, 1'b0, 1'b0);
                exp_o.ph = 1'b0;
                exp_o.sl = 1'b0;
                exp_o.up = 1'b0;
                exp_o.dn = 1'b0;
            end
            @(posedge clk);
            #1;
            check($sformatf("cyc%0d", k), get_out(), exp_o);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Abort a serve in progress with an asynchronous reset between clock edges.
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_mid_serve", get_out(), '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        acc = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            acc = acc | get_out();
        end
        check("idle_after_rst", acc, '0);

        drive(1'b1, 8'h20, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        exp_o    = '0;
        exp_o.st = 3'd1;
        check("serve_after_rst", get_out(), exp_o);

        seen   = 1'b0;
        seen_o = '0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (serve_load) begin
                seen   = 1'b1;
                seen_o = get_out();
            end
        end
        if (!seen) seen_o = get_out();
        exp_o    = '0;
        exp_o.st = 3'd2;
        exp_o.sl = 1'b1;
        check("launch_after_rst", seen_o, exp_o);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
